// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Multi-cycle instruction sequencer for the 3-bit-opcode core.
//            Owns the program counter. Steps each instruction through
//            FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Gates the decoder's
//            Branch/MemRead/MemWrite/RegWrite lines into strobes toward the
//            register file and the data memory. Also implements the Start/Ack
//            program handshake.
// Ports    : Clk, Reset (async, active high)
//            Start                      - begin a program at PC=0 (IDLE/DONE only)
//            Branch/MemRead/MemWrite/RegWrite, Zero, Offset - decoder/ALU inputs
//            MemReady                   - data-memory completion strobe
//            PC                         - instruction memory address
//            IrLoad                     - instruction register capture strobe
//            RegWriteEn                 - register file write strobe
//            MemReadEn, MemWriteEn      - data-memory requests (held in MEM)
//            Busy, Ack, Err             - program status
// Options  : CPU_SEQ_PERF_CNT_EN adds the CycleCount/InstrCount outputs.
//            Both are saturating 16-bit counters.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int unsigned      PCW      = 10,
    parameter int unsigned      OFFW     = 6,
    parameter logic [PCW-1:0]   PROG_END = 10'd1023,
    parameter int unsigned      MAX_WAIT = 15
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Branch,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            RegWrite,
    input  logic            Zero,
    input  logic [OFFW-1:0] Offset,
    input  logic            MemReady,
    output logic [PCW-1:0]  PC,
    output logic            IrLoad,
    output logic            RegWriteEn,
    output logic            MemReadEn,
    output logic            MemWriteEn,
    output logic            Busy,
    output logic            Ack,
`ifdef CPU_SEQ_PERF_CNT_EN
    output logic [15:0]     CycleCount,
    output logic [15:0]     InstrCount,
`endif
    output logic            Err
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_MEM    = 3'd4;
    localparam logic [2:0] c_ST_WB     = 3'd5;
    localparam logic [2:0] c_ST_DONE   = 3'd6;

    localparam int unsigned         c_WAITW    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_WAITW-1:0]  c_MAX_WAIT = c_WAITW'(MAX_WAIT);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [PCW-1:0]     r_pc;
    logic [PCW-1:0]     w_pc_nxt;
    logic [c_WAITW-1:0] r_wait;
    logic [c_WAITW-1:0] w_wait_nxt;
    logic [c_WAITW-1:0] w_wait_inc;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_retire;
    logic               w_taken;
    logic               w_start_acc;
    logic               w_busy;
    logic [PCW-1:0]     w_pc_inc;
    logic [PCW-1:0]     w_pc_br;

    // PC arithmetic wraps silently modulo 2^PCW.
    assign w_pc_inc   = r_pc + PCW'(1);
    assign w_pc_br    = r_pc + {{(PCW-OFFW){Offset[OFFW-1]}}, Offset};
    assign w_wait_inc = r_wait + c_WAITW'(1);

    // ------------------------------------------------------------------
    // State / datapath register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= c_ST_IDLE;
            r_pc    <= '0;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_wait  <= w_wait_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_wait_nxt  = r_wait;
        w_err_nxt   = r_err;
        w_retire    = 1'b0;
        w_taken     = 1'b0;
        w_start_acc = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (Start) begin
                    w_start_acc = 1'b1;
                    w_pc_nxt    = '0;
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH:  w_state_nxt = c_ST_DECODE;
            c_ST_DECODE: w_state_nxt = c_ST_EXEC;
            c_ST_EXEC: begin
                if (Branch) begin
                    w_retire = 1'b1;
                    w_taken  = Zero;
                end else if (MemRead || MemWrite) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = c_ST_MEM;
                end else if (RegWrite) begin
                    w_state_nxt = c_ST_WB;
                end else begin
                    w_retire = 1'b1;
                end
            end
            c_ST_MEM: begin
                // A MemReady arriving on the last allowed cycle wins over the timeout.
                if (MemReady) begin
                    if (RegWrite) begin
                        w_state_nxt = c_ST_WB;
                    end else begin
                        w_retire = 1'b1;
                    end
                end else if (w_wait_inc == c_MAX_WAIT) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_ST_DONE;
                end else begin
                    w_wait_nxt = w_wait_inc;
                end
            end
            c_ST_WB:     w_retire = 1'b1;
            c_ST_DONE: begin
                if (Start) begin
                    w_start_acc = 1'b1;
                    w_pc_nxt    = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = c_ST_FETCH;
                end
            end
            default:     w_state_nxt = c_ST_IDLE;
        endcase

        // The end-of-program check uses the retiring PC, so a taken branch
        // that sits at PROG_END also ends the program.
        if (w_retire) begin
            w_pc_nxt    = w_taken ? w_pc_br : w_pc_inc;
            w_state_nxt = (r_pc == PROG_END) ? c_ST_DONE : c_ST_FETCH;
        end
    end

    // ------------------------------------------------------------------
    // Output logic (decoded from state so async reset clears it at once)
    // ------------------------------------------------------------------
    always_comb begin
        IrLoad     = (r_state == c_ST_FETCH);
        RegWriteEn = (r_state == c_ST_WB);
        MemReadEn  = (r_state == c_ST_MEM) && MemRead;
        MemWriteEn = (r_state == c_ST_MEM) && MemWrite;
        w_busy     = (r_state == c_ST_FETCH) || (r_state == c_ST_DECODE) ||
                     (r_state == c_ST_EXEC)  || (r_state == c_ST_MEM)    ||
                     (r_state == c_ST_WB);
        Busy       = w_busy;
        Ack        = (r_state == c_ST_DONE);
        Err        = r_err;
        PC         = r_pc;
    end

`ifdef CPU_SEQ_PERF_CNT_EN
    logic [15:0] r_cyc_cnt;
    logic [15:0] r_ins_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cyc_cnt <= '0;
            r_ins_cnt <= '0;
        end else if (w_start_acc) begin
            r_cyc_cnt <= '0;
            r_ins_cnt <= '0;
        end else begin
            if (w_busy && (r_cyc_cnt != 16'hFFFF)) begin
                r_cyc_cnt <= r_cyc_cnt + 16'd1;
            end
            if (w_retire && (r_ins_cnt != 16'hFFFF)) begin
                r_ins_cnt <= r_ins_cnt + 16'd1;
            end
        end
    end

    assign CycleCount = r_cyc_cnt;
    assign InstrCount = r_ins_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Self-checking bench for cpu_sequencer. The DUT is built with
//            PROG_END=3 so that programs end quickly. An instruction-level
//            reference model predicts, cycle by cycle, the PC and strobes
//            that follow from the instruction class and the MEM wait count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

    localparam logic [9:0] c_PROG_END = 10'd3;
    localparam int         c_MAX_WAIT = 15;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Branch = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, RegWrite = 1'b0;
    logic       Zero = 1'b0, MemReady = 1'b0;
    logic [5:0] Offset = 6'd0;
    logic [9:0] PC;
    logic       IrLoad, RegWriteEn, MemReadEn, MemWriteEn, Busy, Ack, Err;
`ifdef CPU_SEQ_PERF_CNT_EN
    logic [15:0] CycleCount, InstrCount;
`endif

    always #5 Clk = ~Clk;

    cpu_sequencer #(
        .PCW      (10),
        .OFFW     (6),
        .PROG_END (c_PROG_END),
        .MAX_WAIT (c_MAX_WAIT)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Branch     (Branch),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .Zero       (Zero),
        .Offset     (Offset),
        .MemReady   (MemReady),
        .PC         (PC),
        .IrLoad     (IrLoad),
        .RegWriteEn (RegWriteEn),
        .MemReadEn  (MemReadEn),
        .MemWriteEn (MemWriteEn),
        .Busy       (Busy),
        .Ack        (Ack),
`ifdef CPU_SEQ_PERF_CNT_EN
        .CycleCount (CycleCount),
        .InstrCount (InstrCount),
`endif
        .Err        (Err)
    );

    // Observed vector: PC, then flags IrLoad,RegWriteEn,MemReadEn,MemWriteEn,Busy,Ack,Err
    logic [16:0] obs;
    assign obs = {PC, IrLoad, RegWriteEn, MemReadEn, MemWriteEn, Busy, Ack, Err};

    // Reference model state
    logic [9:0] m_pc;
    bit         m_done;
    bit         m_err;
    int         m_cyc;
    int         m_ins;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [16:0] ev(input logic [9:0] pc, input logic ir, rw, mr, mw,
                                       input logic busy, ack, err);
        return {pc, ir, rw, mr, mw, busy, ack, err};
    endfunction

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic junk();
        {Branch, MemRead, MemWrite, RegWrite, Zero} = 5'($urandom);
        Offset   = 6'($urandom);
        MemReady = 1'($urandom);
    endtask

    // Start a program from IDLE or DONE; checks the status seen in the Start cycle.
    task automatic do_start(input string tag);
        logic [16:0] exp;
        junk();
        Start = 1'b1;
        exp = ev(m_pc, 0, 0, 0, 0, 0, m_done, m_err);
        #1;
        n_checks++;
        if (obs !== exp) $display("FAIL %s start-cycle: got pc=%0d flags=%b, required pc=%0d flags=%b",
                                  tag, obs[16:7], obs[6:0], exp[16:7], exp[6:0]);
        else n_pass++;
`ifdef CPU_SEQ_PERF_CNT_EN
        n_checks++;
        if (CycleCount !== sat16(m_cyc) || InstrCount !== sat16(m_ins))
            $display("FAIL %s perf: got cyc=%0d ins=%0d, required cyc=%0d ins=%0d",
                     tag, CycleCount, InstrCount, sat16(m_cyc), sat16(m_ins));
        else n_pass++;
`endif
        tick();
        Start  = 1'b0;
        m_pc   = 10'd0;
        m_err  = 1'b0;
        m_done = 1'b0;
        m_cyc  = 0;
        m_ins  = 0;
    endtask

    // Execute one instruction starting in FETCH; w = MEM cycles before MemReady
    // (w >= MAX_WAIT means MemReady never comes).
    task automatic exec_instr(input logic br, mr, mw, rw, z, input logic [5:0] off,
                              input int w, input string tag);
        logic [16:0] exp;
        logic [9:0]  nxt;
        bit          to_wb, retire_now;
        // FETCH: decoder lines are not yet valid, drive garbage
        junk();
        Start = 1'($urandom);
        exp = ev(m_pc, 1, 0, 0, 0, 1, 0, 0);
        #1;
        n_checks++;
        if (obs !== exp) $display("FAIL %s fetch: got pc=%0d flags=%b, required pc=%0d flags=%b",
                                  tag, obs[16:7], obs[6:0], exp[16:7], exp[6:0]);
        else n_pass++;
        tick(); m_cyc++;
        // DECODE
        {Branch, MemRead, MemWrite, RegWrite, Zero} = {br, mr, mw, rw, z};
        Offset   = off;
        MemReady = 1'($urandom);
        Start    = 1'($urandom);
        exp = ev(m_pc, 0, 0, 0, 0, 1, 0, 0);
        #1;
        n_checks++;
        if (obs !== exp) $display("FAIL %s decode: got pc=%0d flags=%b, required pc=%0d flags=%b",
                                  tag, obs[16:7], obs[6:0], exp[16:7], exp[6:0]);
        else n_pass++;
        tick(); m_cyc++;
        // EXEC
        MemReady = 1'($urandom);
        Start    = 1'($urandom);
        #1;
        n_checks++;
        if (obs !== exp) $display("FAIL %s exec: got pc=%0d flags=%b, required pc=%0d flags=%b",
                                  tag, obs[16:7], obs[6:0], exp[16:7], exp[6:0]);
        else n_pass++;
        tick(); m_cyc++;

        to_wb      = 1'b0;
        retire_now = 1'b0;
        nxt        = m_pc + 10'd1;
        if (br) begin
            retire_now = 1'b1;
            if (z) nxt = m_pc + {{4{off[5]}}, off};
        end else if (mr || mw) begin
            for (int k = 0; k < c_MAX_WAIT; k++) begin
                MemReady = (k == w);
                Start    = 1'($urandom);
                exp = ev(m_pc, 0, 0, mr, mw, 1, 0, 0);
                #1;
                n_checks++;
                if (obs !== exp) $display("FAIL %s mem[%0d]: got pc=%0d flags=%b, required pc=%0d flags=%b",
                                          tag, k, obs[16:7], obs[6:0], exp[16:7], exp[6:0]);
                else n_pass++;
                tick(); m_cyc++;
                if (k == w) begin
                    if (rw) to_wb = 1'b1;
                    else    retire_now = 1'b1;
                    break;
                end
            end
            if (!to_wb && !retire_now) begin
                m_err  = 1'b1;
                m_done = 1'b1;
            end
        end else if (rw) begin
            to_wb = 1'b1;
        end else begin
            retire_now = 1'b1;
        end

        if (to_wb) begin
            MemReady = 1'($urandom);
            Start    = 1'($urandom);
            exp = ev(m_pc, 0, 1, 0, 0, 1, 0, 0);
            #1;
            n_checks++;
            if (obs !== exp) $display("FAIL %s wb: got pc=%0d flags=%b, required pc=%0d flags=%b",
                                      tag, obs[16:7], obs[6:0], exp[16:7], exp[6:0]);
            else n_pass++;
            tick(); m_cyc++;
            retire_now = 1'b1;
        end

        if (retire_now) begin
            m_ins++;
            m_done = (m_pc == c_PROG_END);
            m_pc   = nxt;
        end
        Start = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] exp;
        // Power-on reset with noisy inputs
        junk();
        Start = 1'b1;
        tick(); tick();
        #1;
        n_checks++;
        if (obs !== 17'd0) $display("FAIL reset-hold: got %b, required all zero", obs);
        else n_pass++;
        Reset = 1'b0;
        Start = 1'b0;
        m_pc = 10'd0; m_done = 1'b0; m_err = 1'b0; m_cyc = 0; m_ins = 0;
        for (int i = 0; i < 2; i++) begin
            junk();
            #1;
            n_checks++;
            if (obs !== 17'd0) $display("FAIL idle[%0d]: got %b, required all zero", i, obs);
            else n_pass++;
            tick();
        end
        // Reset asserted in the middle of WB
        do_start("reset-wb");
        {Branch, MemRead, MemWrite, RegWrite, Zero} = 5'b00010;
        tick(); tick(); tick();
        exp = ev(10'd0, 0, 1, 0, 0, 1, 0, 0);
        #1;
        n_checks++;
        if (obs !== exp) $display("FAIL pre-reset-wb: got pc=%0d flags=%b, required pc=0 flags=%b",
                                  obs[16:7], obs[6:0], exp[6:0]);
        else n_pass++;
        #1 Reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== 17'd0) $display("FAIL reset-mid-wb: got %b, required all zero", obs);
        else n_pass++;
        tick();
        Reset = 1'b0;
        tick();
        #1;
        n_checks++;
        if (obs !== 17'd0) $display("FAIL after-reset-wb: got %b, required all zero", obs);
        else n_pass++;
        m_cyc = 0; m_ins = 0;
`ifdef CPU_SEQ_PERF_CNT_EN
        n_checks++;
        if (CycleCount !== 16'd0 || InstrCount !== 16'd0)
            $display("FAIL reset-perf: got cyc=%0d ins=%0d, required 0 0", CycleCount, InstrCount);
        else n_pass++;
`endif
    endtask

    task automatic test_alu();
        do_start("alu");
        exec_instr(0, 0, 0, 1, 1'($urandom), 6'($urandom), 0, "alu@0");
    endtask

    task automatic test_branch();
        // PC1 -> PC5 via taken branch; other decoder lines must be ignored
        exec_instr(1, 1'($urandom), 1'($urandom), 1'($urandom), 1, 6'd4, 0, "br+4");
        exec_instr(1, 0, 1, 1, 1, 6'b111110, 0, "br-2 taken");
        // PC3 is PROG_END: a no-op there ends the program
        exec_instr(0, 0, 0, 0, 0, 6'd0, 0, "nop@end");
        do_start("branch2");
        exec_instr(1, 0, 0, 0, 1, 6'd5, 0, "br+5");
        exec_instr(1, 0, 1, 1, 0, 6'b111110, 0, "br-2 not taken");
    endtask

    task automatic test_mem();
        exec_instr(0, 1, 0, 1, 0, 6'd0, 3, "load w3");
        exec_instr(0, 0, 1, 0, 0, 6'd0, 0, "store w0");
        exec_instr(0, 0, 1, 0, 0, 6'd0, c_MAX_WAIT - 1, "store edge");
    endtask

    task automatic test_timeout();
        logic [16:0] exp;
        exec_instr(0, 1, 0, 1, 0, 6'd0, 99, "timeout");
        for (int i = 0; i < 3; i++) begin
            junk();
            exp = ev(m_pc, 0, 0, 0, 0, 0, 1, 1);
            #1;
            n_checks++;
            if (obs !== exp) $display("FAIL timeout-done[%0d]: got pc=%0d flags=%b, required pc=%0d flags=%b",
                                      i, obs[16:7], obs[6:0], exp[16:7], exp[6:0]);
            else n_pass++;
            tick();
        end
        do_start("restart");
    endtask

    task automatic test_prog_end();
        logic [16:0] exp;
        time t0;
        t0 = $time;
        for (int i = 0; i < 4; i++) exec_instr(0, 0, 0, 1, 0, 6'd0, 0, "alu-prog");
        n_checks++;
        if (($time - t0) / 10 != 16) $display("FAIL prog-end-latency: got %0d cycles, required 16", ($time - t0) / 10);
        else n_pass++;
        exp = ev(10'd4, 0, 0, 0, 0, 0, 1, 0);
        #1;
        n_checks++;
        if (obs !== exp) $display("FAIL prog-end-done: got pc=%0d flags=%b, required pc=4 flags=%b",
                                  obs[16:7], obs[6:0], exp[6:0]);
        else n_pass++;
`ifdef CPU_SEQ_PERF_CNT_EN
        n_checks++;
        if (CycleCount !== 16'd16 || InstrCount !== 16'd4)
            $display("FAIL prog-end-perf: got cyc=%0d ins=%0d, required 16 4", CycleCount, InstrCount);
        else n_pass++;
`endif
        tick();
    endtask

    task automatic test_wrap();
        do_start("wrap");
        exec_instr(1, 0, 0, 0, 1, 6'b111111, 0, "br to 1023");
        exec_instr(0, 0, 0, 0, 0, 6'd0, 0, "nop@1023");
        exec_instr(0, 0, 0, 0, 0, 6'd0, 0, "nop@0");
    endtask

    task automatic test_random();
        logic [3:0] ops;
        int         w;
        for (int i = 0; i < 300; i++) begin
            if (m_done) do_start("rand");
            ops = 4'($urandom);
            w   = ($urandom_range(0, 9) == 0) ? c_MAX_WAIT : $urandom_range(0, 4);
            exec_instr(ops[3], ops[2], ops[1], ops[0], 1'($urandom), 6'($urandom), w, "rand");
        end
        if (m_done) do_start("rand-final");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_timeout();
        test_prog_end();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
